// File: rtl/fifo_rd_pkg.sv
// Shared sizing and pointer helpers for the FIFO stream reader and its skid buffer.
package fifo_rd_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int BUF_PTR_W = 2;
    localparam int BUF_CNT_W = 2;

    typedef logic [BUF_PTR_W-1:0] buf_ptr_t;
    typedef logic [BUF_CNT_W-1:0] buf_cnt_t;

    // Ring pointer over BUF_DEPTH entries; not a power of two, so wrap explicitly.
    function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
        return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? '0 : p + buf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry register ring that absorbs FIFO read latency; head is the oldest word.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] head,
    output buf_cnt_t         cnt
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    buf_ptr_t         wptr;
    buf_ptr_t         rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[wptr] <= wr_data;
                wptr      <= ptr_inc(wptr);
            end
            if (rd) begin
                rptr <= ptr_inc(rptr);
            end
            case ({wr, rd})
                2'b10:   cnt <= cnt + buf_cnt_t'(1);
                2'b01:   cnt <= cnt - buf_cnt_t'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO and presents the words as a valid/ready stream.
// Define FIFO_RD_PKT_LAST_EN to generate m_last every PKT_LEN beats.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy
);

    if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_bad_pkt_len
        $error("fifo_stream_reader: PKT_LEN must be within 1..65535");
    end

    logic       inflight;
    logic       xfer;
    buf_cnt_t   buf_cnt;
    logic [2:0] occ;

    // Popped-but-not-yet-captured words count against buffer space, so the
    // pop decision never looks at m_ready.
    assign occ        = {1'b0, buf_cnt} + {2'b00, inflight};
    assign fifo_rd_en = en & ~fifo_empty & ~rst & (occ < 3'(BUF_DEPTH));
    assign m_valid    = (buf_cnt != '0);
    assign xfer       = m_valid & m_ready;
    assign busy       = inflight | m_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (xfer) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .wr      (inflight),
        .wr_data (fifo_dout),
        .rd      (xfer),
        .head    (m_data),
        .cnt     (buf_cnt)
    );

`ifdef FIFO_RD_PKT_LAST_EN
    localparam logic [15:0] PKT_LAST_IDX = 16'(PKT_LEN - 1);

    logic [15:0] pkt_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_idx <= '0;
        end else if (xfer) begin
            pkt_idx <= (pkt_idx == PKT_LAST_IDX) ? '0 : pkt_idx + 16'd1;
        end
    end

    assign m_last = m_valid & (pkt_idx == PKT_LAST_IDX);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + randomized bench for fifo_stream_reader against a queue-based FIFO and stream model.
module tb_fifo_stream_reader;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 3;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [CNT_W-1:0] beat_cnt;
    logic             busy;

    fifo_stream_reader #(
        .WIDTH   (WIDTH),
        .PKT_LEN (PKT_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .beat_cnt   (beat_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               last_pos[$];
    int               outstanding = 0;
    int               model_beats = 0;
    bit               pop_prev    = 0;
    bit               hold_prev   = 0;
    bit               mon_on      = 0;
    logic [WIDTH-1:0] hold_data   = '0;
    logic [WIDTH-1:0] last_hs_data = '0;

    logic             s_rd, s_valid, s_busy, s_last;
    logic [WIDTH-1:0] s_data;
    logic [CNT_W-1:0] s_beat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample at negedge, check against the model, advance the model,
    // then model the FIFO read port just after the rising edge.
    task automatic cyc();
        bit   hs;
        bit   exp_valid;
        bit   exp_last;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        s_rd    = fifo_rd_en;
        s_valid = m_valid;
        s_data  = m_data;
        s_busy  = busy;
        s_beat  = beat_cnt;
        s_last  = m_last;
        hs      = s_valid && m_ready && !rst;
        exp_valid = (outstanding - int'(pop_prev)) > 0;
`ifdef FIFO_RD_PKT_LAST_EN
        exp_last = exp_valid && ((model_beats % PKT_LEN) == PKT_LEN - 1);
`else
        exp_last = 1'b0;
`endif
        if (mon_on) begin
            check("pop_when_empty", 32'(s_rd & fifo_empty), 32'd0);
            check("m_valid", 32'(s_valid), 32'(exp_valid));
            check("busy", 32'(s_busy), 32'(outstanding != 0));
            check("beat_cnt", 32'(s_beat), 32'(model_beats % (1 << CNT_W)));
            check("m_last", 32'(s_last), 32'(exp_last));
            check("occupancy_le_3", 32'(outstanding <= 3), 32'd1);
            if (hold_prev) begin
                check("hold_valid", 32'(s_valid), 32'd1);
                check("hold_data", 32'(s_data), 32'(hold_data));
            end
            if (hs) begin
                if (exp_q.size() == 0) check("beat_without_word", 32'(exp_q.size()), 32'd1);
                else check("m_data_order", 32'(s_data), 32'(exp_q.pop_front()));
            end
        end
        hold_prev = s_valid && !m_ready && !rst;
        hold_data = s_data;
        if (rst) begin
            exp_q.delete();
            last_pos.delete();
            outstanding = 0;
            model_beats = 0;
            pop_prev    = 0;
        end else begin
            if (hs) begin
                if (s_last) last_pos.push_back(model_beats + 1);
                last_hs_data = s_data;
                model_beats++;
                outstanding--;
            end
            if (s_rd) outstanding++;
            pop_prev = s_rd;
        end
        @(posedge clk);
        #1;
        if (s_rd && !rst && q.size() > 0) begin
            w = q.pop_front();
            fifo_dout = w;
            exp_q.push_back(w);
        end
        fifo_empty = (q.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        logic [WIDTH-1:0] w0, wb, wc, wlast;
        int   pops;
        bit   rd_hist[10];
        bit   v_hist[10];

        rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
        run(2);
        rst = 1'b0;
        mon_on = 1'b1;
        cyc();
        check("rst_m_valid", 32'(s_valid), 32'd0);
        check("rst_m_data", 32'(s_data), 32'd0);
        check("rst_beat_cnt", 32'(s_beat), 32'd0);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_rd_en", 32'(s_rd), 32'd0);
        check("rst_m_last", 32'(s_last), 32'd0);

        // Stream with no backpressure
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            rd_hist[i] = s_rd;
            v_hist[i]  = s_valid;
        end
        for (int i = 0; i < 4; i++) check("t1_pop_burst", 32'(rd_hist[i]), 32'd1);
        check("t1_pop_stop", 32'(rd_hist[4]), 32'd0);
        check("t1_valid_c1", 32'(v_hist[1]), 32'd0);
        check("t1_valid_c2", 32'(v_hist[2]), 32'd1);
        check("t1_valid_c5", 32'(v_hist[5]), 32'd1);
        check("t1_valid_c6", 32'(v_hist[6]), 32'd0);
        check("t1_last_word", 32'(last_hs_data), 32'h44);
        check("t1_beat_cnt", 32'(s_beat), 32'd4);
        check("t1_busy", 32'(s_busy), 32'd0);

        // Full backpressure
        m_ready = 1'b0;
        w0 = 8'($urandom);
        push(w0);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            pops += int'(s_rd);
        end
        check("t2_pops", 32'(pops), 32'd3);
        check("t2_valid", 32'(s_valid), 32'd1);
        check("t2_head", 32'(s_data), 32'(w0));
        m_ready = 1'b1;
        run(12);
        check("t2_beat_cnt", 32'(s_beat), 32'(10 % 16));
        check("t2_fifo_drained", 32'(q.size()), 32'd0);
        check("t2_all_delivered", 32'(exp_q.size()), 32'd0);

        // Alternating m_ready
        for (int i = 0; i < 8; i++) push(8'($urandom));
        for (int i = 0; i < 30; i++) begin
            m_ready = (i % 2 == 0);
            cyc();
        end
        m_ready = 1'b1;
        run(2);
        check("t3_beat_cnt", 32'(s_beat), 32'(18 % 16));
        check("t3_busy", 32'(s_busy), 32'd0);

        // en dropped one cycle after the second pop
        push(8'hA1); wb = 8'hB2; push(wb); wc = 8'hC3; push(wc);
        run(2);
        en = 1'b0;
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            pops += int'(s_rd);
        end
        check("t4_no_pops", 32'(pops), 32'd0);
        check("t4_second_word", 32'(last_hs_data), 32'(wb));
        check("t4_busy", 32'(s_busy), 32'd0);
        check("t4_left_in_fifo", 32'(q.size()), 32'd1);
        en = 1'b1;
        run(6);
        check("t4_resume_word", 32'(last_hs_data), 32'(wc));
        check("t4_beat_cnt", 32'(s_beat), 32'(21 % 16));

        // Reset with two words buffered and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        wlast = 8'($urandom);
        push(wlast);
        run(3);
        check("t5_busy_before", 32'(s_busy), 32'd1);
        en = 1'b0; rst = 1'b1;
        cyc();
        check("t5_rd_en_in_reset", 32'(s_rd), 32'd0);
        rst = 1'b0;
        cyc();
        check("t5_valid_after", 32'(s_valid), 32'd0);
        check("t5_beat_after", 32'(s_beat), 32'd0);
        check("t5_rd_en_after", 32'(s_rd), 32'd0);
        check("t5_fifo_kept", 32'(q.size()), 32'd2);
        en = 1'b1; m_ready = 1'b1;
        run(8);
        check("t5_beat_cnt", 32'(s_beat), 32'd2);
        check("t5_last_word", 32'(last_hs_data), 32'(wlast));

        // 17 beats from reset: beat_cnt wraps, m_last every PKT_LEN beats
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) push(8'($urandom));
        for (int i = 0; i < 60 && model_beats < 17; i++) cyc();
        cyc();
        check("t6_beats_done", 32'(model_beats), 32'd17);
        check("t6_beat_wrap", 32'(s_beat), 32'd1);
`ifdef FIFO_RD_PKT_LAST_EN
        check("t6_last_count", 32'(last_pos.size()), 32'(17 / PKT_LEN));
        if (last_pos.size() >= 2) begin
            check("t6_last_beat3", 32'(last_pos[0]), 32'd3);
            check("t6_last_beat6", 32'(last_pos[1]), 32'd6);
        end
`else
        check("t6_last_count", 32'(last_pos.size()), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            cyc();
        end
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 200 && (q.size() != 0 || s_busy); i++) cyc();
        run(2);
        check("t7_fifo_drained", 32'(q.size()), 32'd0);
        check("t7_all_delivered", 32'(exp_q.size()), 32'd0);
        check("t7_busy", 32'(s_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
